key_entry: RTL and testbench
============================

KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port strobe, input, 1 bit: key-valid level from the keypad scanner, high while a key is held.
REQ-004 SHALL have port code, input, 5 bits: key code 0..19, valid while strobe is high.
REQ-005 SHALL have port value, output, 32 bits: operand currently being typed.
REQ-006 SHALL have port digits, output, 4 bits: count of entered hex digits, 0..8.
REQ-007 SHALL have port digit_en, output, 8 bits: per-digit display enables; bit i drives the 7-seg decoder enable for nibble i.
REQ-008 SHALL have port a_reg, output, 32 bits: latched operand A.
REQ-009 SHALL have port b_reg, output, 32 bits: latched operand B.
REQ-010 SHALL have port op, output, 5 bits: latched ALU opcode, 0..19.
REQ-011 SHALL have ports load_a, load_b and go, outputs, 1 bit each: one-cycle pulses, asserted when A, B or op latches.
REQ-012 SHALL have port err, output, 1 bit: sticky flag for an invalid opcode entry.
REQ-013 SHALL have port state, output, 2 bits: current FSM state.

Function
REQ-014 SHALL detect a key event only on the first rising clk edge where strobe samples 1 after sampling 0 on the previous edge; a held key yields exactly one event.
REQ-015 SHALL apply all event effects at the detecting edge; load_a, load_b and go SHALL be high for exactly the following cycle.
REQ-016 Codes 0..15 SHALL shift in a nibble when digits<8: value <= {value[27:0], code[3:0]} and digits increments; when digits==8 the key SHALL be ignored, with no wrap and no shift.
REQ-017 Code 16 (backspace) SHALL set value <= value>>4 and decrement digits; when digits==0 it SHALL have no effect.
REQ-018 Code 17 (clear) SHALL set value and digits to 0 and clear err.
REQ-019 Code 18 (enter) SHALL act according to state:
- ENTER_A (0): a_reg<=value, pulse load_a, clear value and digits, go to ENTER_B.
- ENTER_B (1): b_reg<=value, pulse load_b, clear value and digits, go to ENTER_OP.
- ENTER_OP (2): if value<=19, op<=value[4:0], pulse go, clear err, go to SHOW. Otherwise set err, leave value unchanged, stay.
- SHOW (3): clear value and digits, go to ENTER_A.
REQ-020 Code 19 (abort) SHALL return to ENTER_A and clear value, digits and err; a_reg, b_reg and op SHALL be retained.
REQ-021 Digit keys in SHOW SHALL be ignored.
REQ-022 digit_en SHALL be combinational: in SHOW it is 8'hFF; otherwise bit i = (i<digits) or (i==0), so a single 0 is shown when empty.
REQ-023 Key codes above 19 SHALL be ignored.

Reset
REQ-024 While reset is high, all registers SHALL clear immediately: value, digits, a_reg, b_reg, op = 0; load_a, load_b, go, err = 0; state = ENTER_A.
REQ-025 The strobe history register SHALL reset to 1, so a key held through reset deassertion generates no event.
REQ-026 Reset asserted mid-entry SHALL discard the partial entry with no pulse.

Structure
REQ-027 A shared package key_entry_pkg SHALL hold:
- state encodings ST_ENTER_A, ST_ENTER_B, ST_ENTER_OP, ST_SHOW;
- key constants KEY_BS=16, KEY_CLR=17, KEY_ENT=18, KEY_ABORT=19;
- ALU_OP_MAX=19.
REQ-028 Strobe rise detection SHALL be a sub-module key_edge (inputs clk, reset, level; output rise); the remainder is a single FSM and datapath.

Verification
REQ-029 Press 1,2,3 then enter -> value goes 0x1, 0x12, 0x123; a_reg=0x00000123; load_a high one cycle; state=1; digit_en 8'h01 after clear.
REQ-030 Press nine digits F -> value=0xFFFFFFFF, digits=8, and the ninth press is ignored; backspace -> 0x0FFFFFFF, digits=7.
REQ-031 Hold strobe with code 5 for 20 cycles -> exactly one shift, value=0x5.
REQ-032 In ENTER_OP type 1,5 (0x15) and enter -> err=1, state stays 2; clear, then 2, enter -> op=2, go pulse, state=3, digit_en=8'hFF.
REQ-033 A=0x10 latched, in ENTER_B type 7 and abort -> state=0, value=0, a_reg still 0x10.
REQ-034 Assert reset mid-entry with strobe held -> all outputs 0, state=0; after release there is no event until strobe falls and rises again.

Source files
------------

// File: rtl/key_entry_pkg.sv
// Shared types and constants for the keypad operand-entry block.
package key_entry_pkg;

  localparam int unsigned VAL_W      = 32;
  localparam int unsigned DIG_W      = 4;
  localparam int unsigned CODE_W     = 5;
  localparam int unsigned NIBBLES    = 8;

  typedef enum logic [1:0] {
    ST_ENTER_A  = 2'd0,
    ST_ENTER_B  = 2'd1,
    ST_ENTER_OP = 2'd2,
    ST_SHOW     = 2'd3
  } state_t;

  localparam logic [CODE_W-1:0] KEY_BS    = CODE_W'(16);
  localparam logic [CODE_W-1:0] KEY_CLR   = CODE_W'(17);
  localparam logic [CODE_W-1:0] KEY_ENT   = CODE_W'(18);
  localparam logic [CODE_W-1:0] KEY_ABORT = CODE_W'(19);

  localparam logic [VAL_W-1:0]  ALU_OP_MAX = VAL_W'(19);
  localparam logic [DIG_W-1:0]  DIG_FULL   = DIG_W'(NIBBLES);

  // Display enables: everything lit in SHOW, else entered nibbles plus nibble 0.
  function automatic logic [NIBBLES-1:0] digit_enable(input state_t st,
                                                      input logic [DIG_W-1:0] dig);
    logic [NIBBLES-1:0] en;
    en = '0;
    if (st == ST_SHOW) begin
      en = '1;
    end else begin
      for (int i = 0; i < NIBBLES; i++) begin
        en[i] = (DIG_W'(i) < dig) || (i == 0);
      end
    end
    return en;
  endfunction

endpackage

// File: rtl/key_entry_edge.sv
// key_edge: rising-edge detector for the keypad strobe level.
//   clk, reset (async, active-high), level (strobe in), rise (event, same cycle).
// History resets to 1 so a key held across reset release gives no event.
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic r_level_q;

  // Previous-edge sample of the strobe level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_level_q <= 1'b1;
    else       r_level_q <= level;
  end

  assign rise = level & ~r_level_q;

endmodule

// File: rtl/key_entry.sv
// key_entry: keypad operand/opcode entry controller.
//   clk, reset (async, active-high), strobe/code from keypad scanner.
//   value/digits: operand being typed; digit_en: 7-seg nibble enables (comb).
//   a_reg/b_reg/op: latched operands and opcode; load_a/load_b/go: 1-cycle pulses.
//   err: sticky bad-opcode flag; state: current FSM state.
module key_entry
  import key_entry_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                strobe,
  input  logic [CODE_W-1:0]   code,
  output logic [VAL_W-1:0]    value,
  output logic [DIG_W-1:0]    digits,
  output logic [NIBBLES-1:0]  digit_en,
  output logic [VAL_W-1:0]    a_reg,
  output logic [VAL_W-1:0]    b_reg,
  output logic [CODE_W-1:0]   op,
  output logic                load_a,
  output logic                load_b,
  output logic                go,
  output logic                err,
  output logic [1:0]          state
);

  logic                w_rise;
  state_t              r_state, w_state_nx;
  logic [VAL_W-1:0]    r_value, w_value_nx;
  logic [DIG_W-1:0]    r_digits, w_digits_nx;
  logic [VAL_W-1:0]    r_a, w_a_nx;
  logic [VAL_W-1:0]    r_b, w_b_nx;
  logic [CODE_W-1:0]   r_op, w_op_nx;
  logic                r_load_a, w_load_a_nx;
  logic                r_load_b, w_load_b_nx;
  logic                r_go, w_go_nx;
  logic                r_err, w_err_nx;

  key_edge u_edge (
    .clk   (clk),
    .reset (reset),
    .level (strobe),
    .rise  (w_rise)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_ENTER_A;
      r_value  <= '0;
      r_digits <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_load_a <= 1'b0;
      r_load_b <= 1'b0;
      r_go     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_value  <= w_value_nx;
      r_digits <= w_digits_nx;
      r_a      <= w_a_nx;
      r_b      <= w_b_nx;
      r_op     <= w_op_nx;
      r_load_a <= w_load_a_nx;
      r_load_b <= w_load_b_nx;
      r_go     <= w_go_nx;
      r_err    <= w_err_nx;
    end
  end

  // Next-state and datapath decode; only a detected key event changes anything.
  always_comb begin
    w_state_nx  = r_state;
    w_value_nx  = r_value;
    w_digits_nx = r_digits;
    w_a_nx      = r_a;
    w_b_nx      = r_b;
    w_op_nx     = r_op;
    w_load_a_nx = 1'b0;
    w_load_b_nx = 1'b0;
    w_go_nx     = 1'b0;
    w_err_nx    = r_err;

    if (w_rise) begin
      if (code < KEY_BS) begin
        // Hex digit: saturates at eight nibbles, ignored while showing result.
        if (r_state != ST_SHOW && r_digits < DIG_FULL) begin
          w_value_nx  = {r_value[VAL_W-5:0], code[3:0]};
          w_digits_nx = r_digits + DIG_W'(1);
        end
      end else begin
        case (code)
          KEY_BS: begin
            if (r_digits != '0) begin
              w_value_nx  = r_value >> 4;
              w_digits_nx = r_digits - DIG_W'(1);
            end
          end
          KEY_CLR: begin
            w_value_nx  = '0;
            w_digits_nx = '0;
            w_err_nx    = 1'b0;
          end
          KEY_ENT: begin
            case (r_state)
              ST_ENTER_A: begin
                w_a_nx      = r_value;
                w_load_a_nx = 1'b1;
                w_value_nx  = '0;
                w_digits_nx = '0;
                w_state_nx  = ST_ENTER_B;
              end
              ST_ENTER_B: begin
                w_b_nx      = r_value;
                w_load_b_nx = 1'b1;
                w_value_nx  = '0;
                w_digits_nx = '0;
                w_state_nx  = ST_ENTER_OP;
              end
              ST_ENTER_OP: begin
                // Out-of-range opcode keeps the entry so the user can fix it.
                if (r_value <= ALU_OP_MAX) begin
                  w_op_nx    = r_value[CODE_W-1:0];
                  w_go_nx    = 1'b1;
                  w_err_nx   = 1'b0;
                  w_state_nx = ST_SHOW;
                end else begin
                  w_err_nx   = 1'b1;
                end
              end
              default: begin
                w_value_nx  = '0;
                w_digits_nx = '0;
                w_state_nx  = ST_ENTER_A;
              end
            endcase
          end
          KEY_ABORT: begin
            w_value_nx  = '0;
            w_digits_nx = '0;
            w_err_nx    = 1'b0;
            w_state_nx  = ST_ENTER_A;
          end
          default: ;
        endcase
      end
    end
  end

  assign value    = r_value;
  assign digits   = r_digits;
  assign a_reg    = r_a;
  assign b_reg    = r_b;
  assign op       = r_op;
  assign load_a   = r_load_a;
  assign load_b   = r_load_b;
  assign go       = r_go;
  assign err      = r_err;
  assign state    = r_state;
  assign digit_en = digit_enable(r_state, r_digits);

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: a behavioural model pushes the expected
// post-event outputs to a queue as each key is driven; they are popped and
// compared once the DUT has taken the edge.
module tb_key_entry;

  logic        clk;
  logic        reset;
  logic        strobe;
  logic [4:0]  code;
  logic [31:0] value;
  logic [3:0]  digits;
  logic [7:0]  digit_en;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [4:0]  op;
  logic        load_a;
  logic        load_b;
  logic        go;
  logic        err;
  logic [1:0]  state;

  key_entry dut (
    .clk      (clk),
    .reset    (reset),
    .strobe   (strobe),
    .code     (code),
    .value    (value),
    .digits   (digits),
    .digit_en (digit_en),
    .a_reg    (a_reg),
    .b_reg    (b_reg),
    .op       (op),
    .load_a   (load_a),
    .load_b   (load_b),
    .go       (go),
    .err      (err),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic [3:0]  digits;
    logic [7:0]  digit_en;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [4:0]  op;
    logic        load_a;
    logic        load_b;
    logic        go;
    logic        err;
    logic [1:0]  state;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;

  // Model state.
  logic [31:0] m_value;
  int          m_digits;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_op;
  logic        m_err;
  int          m_state;
  logic        m_la, m_lb, m_go;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_value = 0; m_digits = 0; m_a = 0; m_b = 0; m_op = 0;
    m_err = 0; m_state = 0; m_la = 0; m_lb = 0; m_go = 0;
  endtask

  function automatic logic [7:0] model_en();
    int e;
    if (m_state == 3) return 8'hFF;
    e = ((1 << m_digits) - 1) | 1;
    return e[7:0];
  endfunction

  // Behavioural key effect, written from the key table.
  task automatic model_key(input int c);
    m_la = 0; m_lb = 0; m_go = 0;
    if (c <= 15) begin
      if (m_state != 3 && m_digits < 8) begin
        m_value  = (m_value << 4) | 32'(c);
        m_digits = m_digits + 1;
      end
    end else if (c == 16) begin
      if (m_digits > 0) begin
        m_value  = m_value / 16;
        m_digits = m_digits - 1;
      end
    end else if (c == 17) begin
      m_value = 0; m_digits = 0; m_err = 0;
    end else if (c == 18) begin
      if (m_state == 0) begin
        m_a = m_value; m_la = 1; m_value = 0; m_digits = 0; m_state = 1;
      end else if (m_state == 1) begin
        m_b = m_value; m_lb = 1; m_value = 0; m_digits = 0; m_state = 2;
      end else if (m_state == 2) begin
        if (m_value < 20) begin
          m_op = m_value[4:0]; m_go = 1; m_err = 0; m_state = 3;
        end else begin
          m_err = 1;
        end
      end else begin
        m_value = 0; m_digits = 0; m_state = 0;
      end
    end else if (c == 19) begin
      m_value = 0; m_digits = 0; m_err = 0; m_state = 0;
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.value = m_value; e.digits = 4'(m_digits); e.digit_en = model_en();
    e.a_reg = m_a; e.b_reg = m_b; e.op = m_op;
    e.load_a = m_la; e.load_b = m_lb; e.go = m_go;
    e.err = m_err; e.state = 2'(m_state);
    return e;
  endfunction

  task automatic compare_top();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("value",    value,    e.value);
      chk("digits",   32'(digits),   32'(e.digits));
      chk("digit_en", 32'(digit_en), 32'(e.digit_en));
      chk("a_reg",    a_reg,    e.a_reg);
      chk("b_reg",    b_reg,    e.b_reg);
      chk("op",       32'(op),       32'(e.op));
      chk("load_a",   32'(load_a),   32'(e.load_a));
      chk("load_b",   32'(load_b),   32'(e.load_b));
      chk("go",       32'(go),       32'(e.go));
      chk("err",      32'(err),      32'(e.err));
      chk("state",    32'(state),    32'(e.state));
    end
  endtask

  task automatic chk_no_pulse(input string tag);
    chk({tag, "_load_a"}, 32'(load_a), 32'd0);
    chk({tag, "_load_b"}, 32'(load_b), 32'd0);
    chk({tag, "_go"},     32'(go),     32'd0);
  endtask

  // One key press: strobe high for one cycle, then low for one cycle.
  task automatic press(input int c);
    @(negedge clk);
    strobe = 1'b1;
    code   = 5'(c);
    model_key(c);
    sb.push_back(snap());
    @(negedge clk);
    strobe = 1'b0;
    compare_top();
    @(negedge clk);
    chk_no_pulse("after_press");
  endtask

  initial begin
    reset = 1'b1; strobe = 1'b0; code = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_value", value, 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_digit_en", 32'(digit_en), 32'h01);
    chk_no_pulse("rst");
    reset = 1'b0;
    @(negedge clk);

    // Operand A = 0x123
    press(1);  chk("A_v1", value, 32'h1);
    press(2);  chk("A_v12", value, 32'h12);
    press(3);  chk("A_v123", value, 32'h123);
    press(18); chk("A_latched", a_reg, 32'h123);
    chk("A_en_cleared", 32'(digit_en), 32'h01);

    // Operand B: saturation and backspace
    for (int i = 0; i < 9; i++) press(15);
    chk("B_full", value, 32'hFFFF_FFFF);
    chk("B_digits8", 32'(digits), 32'd8);
    press(16);
    chk("B_bs", value, 32'h0FFF_FFFF);
    chk("B_digits7", 32'(digits), 32'd7);
    press(18);

    // Opcode: out of range, then valid
    press(1); press(5); press(18);
    chk("op_err", 32'(err), 32'd1);
    chk("op_stay", 32'(state), 32'd2);
    press(3);                       // err stays sticky through typing
    press(17);
    press(2); press(18);
    chk("op_latched", 32'(op), 32'd2);
    chk("show_en", 32'(digit_en), 32'hFF);
    press(9);                       // digit ignored in SHOW
    press(25);                      // out-of-range code ignored
    press(18);                      // back to ENTER_A

    // Held key: exactly one event
    @(negedge clk);
    strobe = 1'b1; code = 5'd5;
    model_key(5);
    sb.push_back(snap());
    @(negedge clk);
    compare_top();
    repeat (19) @(negedge clk);
    chk("held_value", value, 32'h5);
    chk("held_digits", 32'(digits), 32'd1);
    strobe = 1'b0;
    @(negedge clk);
    press(16); press(16);           // second backspace at zero digits is a no-op
    chk("bs_empty", 32'(digits), 32'd0);

    // Abort retains latched operands
    press(1); press(0); press(18);
    press(7); press(19);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_a", a_reg, 32'h10);

    // Reset mid-entry with strobe held
    press(7);
    @(negedge clk);
    strobe = 1'b1; code = 5'd4;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_value", value, 32'd0);
    chk("mid_rst_digits", 32'(digits), 32'd0);
    chk("mid_rst_a", a_reg, 32'd0);
    chk("mid_rst_b", b_reg, 32'd0);
    chk("mid_rst_op", 32'(op), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk_no_pulse("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_thru_rst_value", value, 32'd0);
    chk("held_thru_rst_digits", 32'(digits), 32'd0);
    strobe = 1'b0;
    press(4);
    chk("post_rst_value", value, 32'h4);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
